inst_utlb: RTL and testbench
============================

# inst_utlb

Instruction micro-TLB between the fetch stage and the shared MMU/TLB lookup port. It translates fetch virtual addresses with a small fully associative cache of 4 KB page translations and answers one cycle after a request. On a miss it stalls fetch and runs a refill handshake against the main TLB. Unmapped segments (kseg0/kseg1) and user-mode illegal accesses are resolved locally without a lookup.

## Interface
- ENTRIES, 4, number of cached translations; power of two, 2..16.
- clk  in  1  clock.
- rst  in  1  reset; one clock, asynchronous and active-high.
- asid  in  8  current ASID.
- is_user_mode  in  1  fetch is in user mode.
- kseg0_uncached  in  1  Config.K0 selects uncached for kseg0.
- flush  in  1  invalidate all entries (TLBWI/TLBWR/ASID write).
- req  in  1  fetch request valid.
- req_vaddr  in  32  fetch virtual address.
- stall  out  1  fetch must hold req/req_vaddr; new requests are ignored.
- resp_valid  out  1  translation result valid (single-cycle pulse).
- resp_paddr  out  32  physical address.
- resp_miss  out  1  TLB refill exception.
- resp_invalid  out  1  TLB invalid exception.
- resp_illegal  out  1  address error (user access to vaddr[31]=1).
- resp_uncached  out  1  uncached fetch.
- lookup_req  out  1  main-TLB lookup request; level, held until lookup_ack.
- lookup_vaddr  out  32  address being looked up; stable while lookup_req=1.
- lookup_ack  in  1  main-TLB result valid this cycle (≥1 cycle after lookup_req rises).
- lookup_miss  in  1  no matching main-TLB entry.
- lookup_valid  in  1  V bit of the matching entry.
- lookup_global  in  1  G bit of the matching entry.
- lookup_pfn  in  20  physical frame number.
- lookup_uncached  in  1  cache attribute is 2 (uncached).

## Operation
- The entry holds valid, vpn[19:0], asid[7:0], global, pfn[19:0], and uncached. Hit = valid && vpn==vaddr[31:12] && (global || asid match).
- Mapped = ~vaddr[31] || vaddr[31:30]==2'b11.
- Classification of an accepted request (req && !stall), in priority order:
  1. is_user_mode && vaddr[31]: respond illegal, paddr = {3'b0, vaddr[28:0]}.
  2. Unmapped: paddr = {3'b0, vaddr[28:0]}. Uncached = (vaddr[31:29]==3'b101) || (kseg0_uncached && vaddr[31:29]==3'b100).
  3. Mapped hit: paddr = {pfn, vaddr[11:0]}, uncached from the entry.
  4. Mapped miss: go to REFILL.
- FSM states: IDLE, REFILL.
  - IDLE → REFILL on an accepted mapped miss. The block latches vaddr and asserts lookup_req and stall.
  - REFILL → IDLE on lookup_ack.
    - If !lookup_miss && lookup_valid: install the entry at a round-robin victim pointer (pointer advances modulo ENTRIES) and respond hit.
    - If lookup_miss: respond with resp_miss=1 and install nothing.
    - If !lookup_miss && !lookup_valid: respond with resp_invalid=1 and install nothing.
- flush clears every valid bit in the same cycle edge.
  - flush together with req: the flush takes effect first, so a mapped request misses.
  - flush during REFILL: the refill completes and the response is delivered, but the install is suppressed.
- Only one outstanding refill at a time. Exception responses never modify the cache.

## Timing
- Reset values: state=IDLE, all valid=0, victim pointer=0, stall=0, lookup_req=0, resp_valid=0, all resp_* = 0, lookup_vaddr=0.
- Hit, unmapped, or illegal request accepted in cycle N: resp_valid=1 in N+1. Back-to-back requests give a response every cycle.
- Miss accepted in N:
  - stall=1 and lookup_req=1 from N+1.
  - With lookup_ack in cycle M: resp_valid=1 and stall=0 in M+1, lookup_req=0 in M+1.
  - Minimum miss latency is 3 cycles (ack at N+2).
- A request in M+1 may hit the entry installed at M.
- rst asserted mid-refill: FSM returns to IDLE immediately. A lookup_ack arriving later in IDLE is ignored.
- All outputs are registered. No combinational path from req_vaddr to resp_*.

## Test plan
- Reset, then req vaddr 0x8000_1234 → N+1: resp_valid, paddr 0x0000_1234, uncached=0. Repeat with kseg0_uncached=1 → uncached=1. Then 0xA000_0010 → paddr 0x0000_0010, uncached=1.
- asid=5, req 0x0040_0ABC misses → lookup_req with lookup_vaddr 0x0040_0ABC. Ack with pfn=0x12345, valid, not global, 2 cycles later → paddr 0x1234_5ABC. Re-request → hit in 1 cycle. asid=6 → miss again.
- Lookup returns lookup_miss=1 → resp_miss=1 with no install; the same vaddr requested again misses again. Then valid=0 → resp_invalid=1.
- is_user_mode=1, req 0x8000_0000 → resp_illegal=1, lookup_req never rises.
- Fill 5 distinct pages with ENTRIES=4 → first page evicted (pointer wrap), pages 2-5 hit. flush during a 6th refill → response delivered, next request to page 6 misses.
- Assert rst while lookup_req=1, then ack after reset → stall=0, resp_valid stays 0, cache empty.

Source files
------------

// File: rtl/inst_utlb.sv
// Instruction micro-TLB: small fully associative cache of 4 KB translations in front of
// the shared main-TLB lookup port, with a single-outstanding refill handshake.
module inst_utlb #(
  parameter int ENTRIES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  asid,
  input  logic        is_user_mode,
  input  logic        kseg0_uncached,
  input  logic        flush,
  input  logic        req,
  input  logic [31:0] req_vaddr,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_paddr,
  output logic        resp_miss,
  output logic        resp_invalid,
  output logic        resp_illegal,
  output logic        resp_uncached,
  output logic        lookup_req,
  output logic [31:0] lookup_vaddr,
  input  logic        lookup_ack,
  input  logic        lookup_miss,
  input  logic        lookup_valid,
  input  logic        lookup_global,
  input  logic [19:0] lookup_pfn,
  input  logic        lookup_uncached
);

  localparam int PTR_W = $clog2(ENTRIES);

  typedef enum logic {IDLE, REFILL} state_t;
  state_t state, state_nxt;

  logic [ENTRIES-1:0] valid_q;
  logic [19:0]        vpn_q    [ENTRIES];
  logic [7:0]         asid_q   [ENTRIES];
  logic               global_q [ENTRIES];
  logic [19:0]        pfn_q    [ENTRIES];
  logic               unc_q    [ENTRIES];
  logic [PTR_W-1:0]   victim_ptr;
  logic [7:0]         refill_asid;
  logic               flush_seen;

  logic               accept, mapped, start_refill, install;
  logic [ENTRIES-1:0] hit_vec;
  logic               hit_any, hit_unc;
  logic [19:0]        hit_pfn;

  logic        nxt_valid, nxt_miss, nxt_invalid, nxt_illegal, nxt_uncached;
  logic [31:0] nxt_paddr;

  // stall and lookup_req are pure decodes of the state flop, so they stay registered
  assign stall      = (state == REFILL);
  assign lookup_req = (state == REFILL);

  assign accept = req && !stall;
  assign mapped = ~req_vaddr[31] || (req_vaddr[31:30] == 2'b11);

  // A concurrent flush wins over lookup, so a flushed entry can never hit
  always_comb begin
    hit_any = 1'b0;
    hit_pfn = '0;
    hit_unc = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      hit_vec[i] = valid_q[i] && !flush && (vpn_q[i] == req_vaddr[31:12]) &&
                   (global_q[i] || (asid_q[i] == asid));
      if (hit_vec[i]) begin
        hit_any = 1'b1;
        hit_pfn = pfn_q[i];
        hit_unc = unc_q[i];
      end
    end
  end

  assign start_refill = (state == IDLE) && (state_nxt == REFILL);
  assign install = (state == REFILL) && lookup_ack && !lookup_miss && lookup_valid &&
                   !flush_seen && !flush;

  always_comb begin
    state_nxt    = state;
    nxt_valid    = 1'b0;
    nxt_paddr    = '0;
    nxt_miss     = 1'b0;
    nxt_invalid  = 1'b0;
    nxt_illegal  = 1'b0;
    nxt_uncached = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_user_mode && req_vaddr[31]) begin
            nxt_valid   = 1'b1;
            nxt_illegal = 1'b1;
            nxt_paddr   = {3'b000, req_vaddr[28:0]};
          end else if (!mapped) begin
            nxt_valid    = 1'b1;
            nxt_paddr    = {3'b000, req_vaddr[28:0]};
            nxt_uncached = (req_vaddr[31:29] == 3'b101) ||
                           (kseg0_uncached && (req_vaddr[31:29] == 3'b100));
          end else if (hit_any) begin
            nxt_valid    = 1'b1;
            nxt_paddr    = {hit_pfn, req_vaddr[11:0]};
            nxt_uncached = hit_unc;
          end else begin
            state_nxt = REFILL;
          end
        end
      end
      REFILL: begin
        if (lookup_ack) begin
          state_nxt = IDLE;
          nxt_valid = 1'b1;
          if (lookup_miss) begin
            nxt_miss = 1'b1;
          end else if (!lookup_valid) begin
            nxt_invalid = 1'b1;
          end else begin
            nxt_paddr    = {lookup_pfn, lookup_vaddr[11:0]};
            nxt_uncached = lookup_uncached;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state and responses; flush_seen remembers a flush that landed mid-refill
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      valid_q       <= '0;
      victim_ptr    <= '0;
      resp_valid    <= 1'b0;
      resp_paddr    <= '0;
      resp_miss     <= 1'b0;
      resp_invalid  <= 1'b0;
      resp_illegal  <= 1'b0;
      resp_uncached <= 1'b0;
      lookup_vaddr  <= '0;
      refill_asid   <= '0;
      flush_seen    <= 1'b0;
    end else begin
      state         <= state_nxt;
      resp_valid    <= nxt_valid;
      resp_paddr    <= nxt_paddr;
      resp_miss     <= nxt_miss;
      resp_invalid  <= nxt_invalid;
      resp_illegal  <= nxt_illegal;
      resp_uncached <= nxt_uncached;
      if (flush) valid_q <= '0;
      if (install) begin
        valid_q[victim_ptr] <= 1'b1;
        victim_ptr          <= victim_ptr + PTR_W'(1);
      end
      if (start_refill) begin
        lookup_vaddr <= req_vaddr;
        refill_asid  <= asid;
        flush_seen   <= 1'b0;
      end else if ((state == REFILL) && flush) begin
        flush_seen <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (install) begin
      vpn_q[victim_ptr]    <= lookup_vaddr[31:12];
      asid_q[victim_ptr]   <= refill_asid;
      global_q[victim_ptr] <= lookup_global;
      pfn_q[victim_ptr]    <= lookup_pfn;
      unc_q[victim_ptr]    <= lookup_uncached;
    end
  end

endmodule

// File: tb/tb_inst_utlb.sv
// Directed self-checking bench for inst_utlb: unmapped/illegal paths, refill handshake,
// exception responses, round-robin eviction, flush and reset during refill.
module tb_inst_utlb;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  asid;
  logic        is_user_mode, kseg0_uncached, flush, req;
  logic [31:0] req_vaddr;
  logic        stall, resp_valid, resp_miss, resp_invalid, resp_illegal, resp_uncached;
  logic [31:0] resp_paddr, lookup_vaddr;
  logic        lookup_req, lookup_ack, lookup_miss, lookup_valid, lookup_global, lookup_uncached;
  logic [19:0] lookup_pfn;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_utlb #(.ENTRIES(4)) dut (
    .clk(clk), .rst(rst), .asid(asid), .is_user_mode(is_user_mode),
    .kseg0_uncached(kseg0_uncached), .flush(flush), .req(req), .req_vaddr(req_vaddr),
    .stall(stall), .resp_valid(resp_valid), .resp_paddr(resp_paddr), .resp_miss(resp_miss),
    .resp_invalid(resp_invalid), .resp_illegal(resp_illegal), .resp_uncached(resp_uncached),
    .lookup_req(lookup_req), .lookup_vaddr(lookup_vaddr), .lookup_ack(lookup_ack),
    .lookup_miss(lookup_miss), .lookup_valid(lookup_valid), .lookup_global(lookup_global),
    .lookup_pfn(lookup_pfn), .lookup_uncached(lookup_uncached)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Drive a request for one cycle; returns at the negedge after the sampling edge
  task automatic applyStimulus(input logic r, input logic [31:0] va);
    req       = r;
    req_vaddr = va;
    @(negedge clk);
  endtask

  // Waits (bounded) for lookup_req, idles one cycle, then acks for one cycle
  task automatic ackLookup(input logic miss, input logic vld, input logic glb,
                           input logic [19:0] pfn, input logic unc);
    int waited = 0;
    while (!lookup_req && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("lookup_req_wait", 32'(lookup_req), 1);
    @(negedge clk);
    lookup_ack      = 1'b1;
    lookup_miss     = miss;
    lookup_valid    = vld;
    lookup_global   = glb;
    lookup_pfn      = pfn;
    lookup_uncached = unc;
    @(negedge clk);
    lookup_ack = 1'b0;
    req        = 1'b0;
  endtask

  task automatic expectHit(input string tag, input logic [31:0] va, input logic [31:0] pa);
    applyStimulus(1'b1, va);
    checkOutput({tag, "_valid"}, 32'(resp_valid), 1);
    checkOutput({tag, "_paddr"}, resp_paddr, pa);
    checkOutput({tag, "_stall"}, 32'(stall), 0);
  endtask

  task automatic expectMiss(input string tag, input logic [31:0] va);
    applyStimulus(1'b1, va);
    checkOutput({tag, "_valid"}, 32'(resp_valid), 0);
    checkOutput({tag, "_stall"}, 32'(stall), 1);
    checkOutput({tag, "_lvaddr"}, lookup_vaddr, va);
  endtask

  initial begin
    rst = 1'b1; asid = 8'd0; is_user_mode = 1'b0; kseg0_uncached = 1'b0; flush = 1'b0;
    req = 1'b0; req_vaddr = '0; lookup_ack = 1'b0; lookup_miss = 1'b0; lookup_valid = 1'b0;
    lookup_global = 1'b0; lookup_pfn = '0; lookup_uncached = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_stall", 32'(stall), 0);
    checkOutput("rst_resp_valid", 32'(resp_valid), 0);
    checkOutput("rst_lookup_req", 32'(lookup_req), 0);
    checkOutput("rst_lookup_vaddr", lookup_vaddr, 0);
    checkOutput("rst_paddr", resp_paddr, 0);
    rst = 1'b0;
    @(negedge clk);

    // Unmapped kseg0 / kseg1
    expectHit("k0", 32'h8000_1234, 32'h0000_1234);
    checkOutput("k0_unc", 32'(resp_uncached), 0);
    applyStimulus(1'b0, '0);
    checkOutput("pulse_end", 32'(resp_valid), 0);
    kseg0_uncached = 1'b1;
    expectHit("k0u", 32'h8000_1234, 32'h0000_1234);
    checkOutput("k0u_unc", 32'(resp_uncached), 1);
    kseg0_uncached = 1'b0;
    expectHit("k1", 32'hA000_0010, 32'h0000_0010);
    checkOutput("k1_unc", 32'(resp_uncached), 1);
    applyStimulus(1'b0, '0);

    // Mapped miss, refill at minimum latency, then hit, then ASID mismatch
    asid = 8'd5;
    expectMiss("m1", 32'h0040_0ABC);
    checkOutput("m1_lreq", 32'(lookup_req), 1);
    ackLookup(1'b0, 1'b1, 1'b0, 20'h12345, 1'b0);
    checkOutput("m1_valid", 32'(resp_valid), 1);
    checkOutput("m1_paddr", resp_paddr, 32'h1234_5ABC);
    checkOutput("m1_stall", 32'(stall), 0);
    checkOutput("m1_lreq_drop", 32'(lookup_req), 0);
    checkOutput("m1_miss", 32'(resp_miss), 0);
    expectHit("h1", 32'h0040_0ABC, 32'h1234_5ABC);
    applyStimulus(1'b0, '0);
    asid = 8'd6;
    expectMiss("m2", 32'h0040_0ABC);
    ackLookup(1'b0, 1'b1, 1'b0, 20'h00777, 1'b0);
    checkOutput("m2_paddr", resp_paddr, 32'h0077_7ABC);

    // Exception responses never install
    expectMiss("m3", 32'h0050_0000);
    ackLookup(1'b1, 1'b0, 1'b0, 20'h0, 1'b0);
    checkOutput("m3_valid", 32'(resp_valid), 1);
    checkOutput("m3_rmiss", 32'(resp_miss), 1);
    expectMiss("m4", 32'h0050_0000);
    ackLookup(1'b0, 1'b0, 1'b0, 20'h0, 1'b0);
    checkOutput("m4_valid", 32'(resp_valid), 1);
    checkOutput("m4_inval", 32'(resp_invalid), 1);
    checkOutput("m4_rmiss", 32'(resp_miss), 0);

    // User access to kseg is illegal and never looks up
    is_user_mode = 1'b1;
    expectHit("ill", 32'h8000_0000, 32'h0000_0000);
    checkOutput("ill_flag", 32'(resp_illegal), 1);
    checkOutput("ill_lreq", 32'(lookup_req), 0);
    applyStimulus(1'b0, '0);
    checkOutput("ill_lreq2", 32'(lookup_req), 0);
    is_user_mode = 1'b0;

    // Flush, then fill five pages into four entries: first page is evicted
    flush = 1'b1;
    applyStimulus(1'b0, '0);
    flush = 1'b0;
    expectMiss("f1", 32'h0040_0ABC);
    ackLookup(1'b0, 1'b1, 1'b0, 20'h00777, 1'b0);
    for (int p = 1; p <= 4; p++) begin
      expectMiss("fill", {12'h000, 4'(p), 16'h0000});
      ackLookup(1'b0, 1'b1, 1'b0, 20'h10000 + 20'(p), 1'b0);
      checkOutput("fill_paddr", resp_paddr, {20'h10000 + 20'(p), 12'h000});
    end
    // Back-to-back hits on pages 2-5
    for (int p = 1; p <= 4; p++)
      expectHit("bb", {12'h000, 4'(p), 16'h0123}, {20'h10000 + 20'(p), 12'h123});
    expectMiss("evict", 32'h0040_0ABC);

    // Flush during this refill: response still arrives, install suppressed
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    ackLookup(1'b0, 1'b1, 1'b0, 20'h00999, 1'b0);
    checkOutput("fl_valid", 32'(resp_valid), 1);
    checkOutput("fl_paddr", resp_paddr, 32'h0099_9ABC);
    expectMiss("fl_again", 32'h0040_0ABC);
    ackLookup(1'b1, 1'b0, 1'b0, 20'h0, 1'b0);
    expectMiss("fl_p3", 32'h0003_0040);
    ackLookup(1'b0, 1'b1, 1'b0, 20'h0ABCD, 1'b1);
    checkOutput("fl_p3_unc", 32'(resp_uncached), 1);
    expectHit("p3_hit", 32'h0003_0040, 32'h0ABC_D040);
    checkOutput("p3_hit_unc", 32'(resp_uncached), 1);

    // Reset while a refill is outstanding; a late ack is ignored
    expectMiss("rr", 32'h0005_0000);
    rst = 1'b1;
    #1;
    checkOutput("rr_stall", 32'(stall), 0);
    checkOutput("rr_lreq", 32'(lookup_req), 0);
    @(negedge clk);
    rst = 1'b0;
    req = 1'b0;
    lookup_ack = 1'b1; lookup_miss = 1'b0; lookup_valid = 1'b1; lookup_pfn = 20'h55555;
    @(negedge clk);
    lookup_ack = 1'b0;
    checkOutput("rr_late_valid", 32'(resp_valid), 0);
    checkOutput("rr_late_stall", 32'(stall), 0);
    expectMiss("rr_empty", 32'h0003_0040);
    ackLookup(1'b1, 1'b0, 1'b0, 20'h0, 1'b0);
    checkOutput("rr_done", 32'(resp_miss), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
